// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner selection for the one-hot bus mux.
// Grants one of four sources (PC, MDR, ALU, MARMUX), holds the select for
// the whole transfer and hands over to the next requester on the release
// edge with no idle cycle in between.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no owner, Gate = 0000, arbitrating on every edge
// S_OWN  | Owner holds the bus, cnt counts cycles of the current grant
module bus_gate_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] Req,
    input  logic [3:0] Last,
    input  logic       Err_clr,
    output logic [3:0] Gate,
    output logic       Bus_idle,
    output logic [1:0] Owner,
    output logic       Timeout_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gate_q, gate_d;
    logic       err_q, err_d;

    logic       own_req;
    logic       own_last;
    logic       hit_limit;
    logic       forced;
    logic       release_now;
    logic [3:0] others;
    logic [2:0] pick_idle;
    logic [2:0] pick_next;

    // Returns {found, index} of the first set bit of req searching from start.
    // Iterating from the farthest offset back to start lets the closest hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + i[1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Release conditions for the current owner and the arbitration candidates.
    always_comb begin
        own_req     = Req[owner_q];
        own_last    = Last[owner_q];
        hit_limit   = (cnt_q == CNT_LAST);
        // A normal end or an abort on the limit cycle is not a forced release.
        forced      = own_req & ~own_last & hit_limit;
        release_now = (state_q == S_OWN) & ((own_req & own_last) | ~own_req | hit_limit);
        // The releasing owner is masked out so it cannot be re-granted at once.
        others      = Req & ~onehot(owner_q);
        pick_idle   = rr_pick(Req, ptr_q);
        pick_next   = rr_pick(others, owner_q + 2'd1);
    end

    // Next-state, pointer, hold counter, error flag and registered select.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        gate_d  = 4'b0000;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (pick_idle[2]) begin
                    state_d = S_OWN;
                    owner_d = pick_idle[1:0];
                end
            end
            S_OWN: begin
                if (release_now) begin
                    ptr_d = owner_q + 2'd1;
                    cnt_d = 8'd0;
                    if (pick_next[2]) begin
                        owner_d = pick_next[1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Setting beats clearing when both happen in one cycle.
        if (forced) begin
            err_d = 1'b1;
        end else if (Err_clr) begin
            err_d = 1'b0;
        end

        if (state_d == S_OWN) begin
            gate_d = onehot(owner_d);
        end
    end

    // State register; reset drops the select asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= 8'd0;
            gate_q  <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        Gate        = gate_q;
        Bus_idle    = ~|gate_q;
        Owner       = owner_q;
        Timeout_err = err_q;
    end

endmodule
